// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI command-frame controller.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_COMMIT
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_HDR  = 3'd1;
    localparam logic [2:0] ERR_BAD_LEN  = 3'd2;
    localparam logic [2:0] ERR_BAD_CSUM = 3'd3;
    localparam logic [2:0] ERR_CS_ABORT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

    // Index width for an n-entry buffer; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic in_frame(input state_t s);
        return (s == S_CMD) || (s == S_LEN) || (s == S_PAYLOAD) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Byte stream from the SPI slave plus the register-bank write port.
interface spi_frame_ctrl_if #(
    parameter int AW = 4
);
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport master (
        output rx_valid, rx_byte,
        input  tx_data, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rx_valid, rx_byte,
        output tx_data, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_frame_buf.sv
// Payload holding buffer: synchronous write, asynchronous read.
module spi_frame_buf
    import spi_frame_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int IW      = idx_w(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/spi_frame_ctrl.sv
// Parses HDR/CMD/LEN/payload/XOR-checksum frames from the SPI slave and
// commits verified payloads to the register bank one byte per clock.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         MAX_LEN = 8,
    parameter int         TIMEOUT = 4096,
    parameter int         AW      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    spi_frame_ctrl_if.slave  bus,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic             busy
);
    localparam int IW = idx_w(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic [AW-1:0] base, base_n;
    logic [7:0]    xor_acc, xor_n;
    logic [IW-1:0] last_idx, last_n, idx, idx_n;
    logic [3:0]    frame_cnt, cnt_n;
    logic [2:0]    err_n;
    logic          ferr_n, fok_n, buf_we;
    logic [7:0]    buf_rd;
    logic [TW-1:0] tmr;
    logic          cs_meta, cs_s, cs_d;
    logic          byte_ok, cs_rise, in_frm, tmo, commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_d    <= 1'b1;
        end else begin
            cs_meta <= cs_n;
            cs_s    <= cs_meta;
            cs_d    <= cs_s;
        end
    end

    assign byte_ok = bus.rx_valid & ~cs_s;
    assign cs_rise = cs_s & ~cs_d;
    assign in_frm  = in_frame(state);
    assign commit  = (state == S_COMMIT);
    // Abort on the edge where the counter would reach TIMEOUT-1, so the
    // error pulse lands exactly TIMEOUT clocks after the last byte strobe.
    assign tmo     = in_frm && (tmr == TW'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    tmr <= '0;
        else if (!in_frm || bus.rx_valid) tmr <= '0;
        else                           tmr <= tmr + 1'b1;
    end

    always_comb begin
        state_n = state;
        base_n  = base;
        xor_n   = xor_acc;
        last_n  = last_idx;
        idx_n   = idx;
        cnt_n   = frame_cnt;
        err_n   = err_code;
        ferr_n  = 1'b0;
        fok_n   = 1'b0;
        buf_we  = 1'b0;
        if (in_frm && cs_rise) begin
            err_n   = ERR_CS_ABORT;
            ferr_n  = 1'b1;
            state_n = S_IDLE;
        end else if (tmo) begin
            err_n   = ERR_TIMEOUT;
            ferr_n  = 1'b1;
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (byte_ok) begin
                    if (bus.rx_byte == HDR) begin
                        state_n = S_CMD;
                    end else begin
                        err_n  = ERR_BAD_HDR;
                        ferr_n = 1'b1;
                    end
                end
                S_CMD: if (byte_ok) begin
                    base_n  = bus.rx_byte[AW-1:0];
                    xor_n   = bus.rx_byte;
                    state_n = S_LEN;
                end
                S_LEN: if (byte_ok) begin
                    if (bus.rx_byte == 8'd0 || bus.rx_byte > 8'(MAX_LEN)) begin
                        err_n   = ERR_BAD_LEN;
                        ferr_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        last_n  = IW'(bus.rx_byte - 8'd1);
                        xor_n   = xor_acc ^ bus.rx_byte;
                        idx_n   = '0;
                        state_n = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (byte_ok) begin
                    buf_we = 1'b1;
                    xor_n  = xor_acc ^ bus.rx_byte;
                    if (idx == last_idx) state_n = S_CSUM;
                    else                 idx_n   = idx + 1'b1;
                end
                S_CSUM: if (byte_ok) begin
                    if (bus.rx_byte == xor_acc) begin
                        idx_n   = '0;
                        state_n = S_COMMIT;
                    end else begin
                        err_n   = ERR_BAD_CSUM;
                        ferr_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_COMMIT: begin
                    if (byte_ok) begin
                        err_n  = ERR_OVERRUN;
                        ferr_n = 1'b1;
                    end
                    if (idx == last_idx) begin
                        fok_n   = 1'b1;
                        cnt_n   = frame_cnt + 4'd1;
                        state_n = S_IDLE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            base        <= '0;
            xor_acc     <= '0;
            last_idx    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            err_code    <= ERR_NONE;
            frame_err   <= 1'b0;
            frame_ok    <= 1'b0;
            bus.tx_data <= '0;
        end else begin
            state       <= state_n;
            base        <= base_n;
            xor_acc     <= xor_n;
            last_idx    <= last_n;
            idx         <= idx_n;
            frame_cnt   <= cnt_n;
            err_code    <= err_n;
            frame_err   <= ferr_n;
            frame_ok    <= fok_n;
            bus.tx_data <= {frame_cnt, err_code, busy};
        end
    end

    spi_frame_buf #(
        .MAX_LEN(MAX_LEN)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(idx),
        .wdata(bus.rx_byte),
        .raddr(idx),
        .rdata(buf_rd)
    );

    assign busy        = (state != S_IDLE);
    assign bus.wr_en   = commit;
    assign bus.wr_addr = commit ? base + AW'(idx) : '0;
    assign bus.wr_data = commit ? buf_rd : '0;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: frame-level reference model feeds
// expectation queues that a negedge monitor drains.
module tb_spi_frame_ctrl;
    import spi_frame_pkg::*;

    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         MAX_LEN = 8;
    localparam int         TIMEOUT = 40;
    localparam int         AW      = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n  = 1'b1;
    logic       frame_ok, frame_err, busy;
    logic [2:0] err_code;

    spi_frame_ctrl_if #(.AW(AW)) bus ();

    spi_frame_ctrl #(
        .HDR(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .bus(bus),
        .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int code; int cyc; } ev_t;

    wr_t        wq[$];
    ev_t        eq[$];
    int         okq[$];
    int         checks = 0, failures = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    logic [3:0] exp_cnt = '0;
    logic [2:0] exp_err = '0;
    logic [7:0] pl [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t w;
        ev_t e;
        int  oc;
        if (mon_en) begin
            if (bus.wr_en) begin
                chk("wr_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("wr_addr", int'(bus.wr_addr), w.addr);
                    chk("wr_data", int'(bus.wr_data), w.data);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end
            if (frame_ok) begin
                chk("ok_expected", int'(okq.size() > 0), 1);
                if (okq.size() > 0) begin
                    oc = okq.pop_front();
                    chk("ok_cycle", cyc, oc);
                end
            end
            if (frame_err) begin
                chk("err_expected", int'(eq.size() > 0), 1);
                if (eq.size() > 0) begin
                    e = eq.pop_front();
                    chk("err_code", int'(err_code), e.code);
                    if (e.cyc >= 0) chk("err_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push_err(input logic [2:0] code, input int c);
        eq.push_back('{int'(code), c});
        exp_err = code;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int r);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        r = cyc;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    function automatic int rgap();
        return int'($urandom_range(0, 3));
    endfunction

    // Reference model: whole-frame outcome from the protocol rules; payload in pl[].
    task automatic do_frame(input logic [7:0] hdr, input logic [7:0] cmd,
                            input logic [7:0] len, input logic [7:0] cmask,
                            input int ovr_gap);
        int r, rc;
        logic [7:0] x, cs;
        send_byte(hdr, rgap(), r);
        if (hdr != HDR) begin push_err(ERR_BAD_HDR, r + 1); return; end
        send_byte(cmd, rgap(), r);
        send_byte(len, rgap(), r);
        if (len == 8'd0 || int'(len) > MAX_LEN) begin push_err(ERR_BAD_LEN, r + 1); return; end
        x = cmd ^ len;
        for (int i = 0; i < int'(len); i++) begin
            x ^= pl[i];
            send_byte(pl[i], rgap(), r);
        end
        cs = x ^ cmask;
        send_byte(cs, rgap(), rc);
        if (cs != x) begin push_err(ERR_BAD_CSUM, rc + 1); return; end
        for (int i = 0; i < int'(len); i++)
            wq.push_back('{(int'(cmd) + i) & (2**AW - 1), int'(pl[i]), rc + 1 + i});
        okq.push_back(rc + 1 + int'(len));
        exp_cnt = exp_cnt + 4'd1;
        if (ovr_gap >= 0) begin
            send_byte(8'h5A, ovr_gap, r);
            if (r >= rc + 1 && r <= rc + int'(len)) push_err(ERR_OVERRUN, r + 1);
            else                                    push_err(ERR_BAD_HDR, r + 1);
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (wq.size() + eq.size() + okq.size()) > 0; i++)
            @(posedge clk);
        chk("drain_pending", wq.size() + eq.size() + okq.size(), 0);
        wq.delete(); eq.delete(); okq.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("tx_data", int'(bus.tx_data), int'({exp_cnt, exp_err, 1'b0}));
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
        chk({tag, "_frame_ok"}, int'(frame_ok), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        cs_n  = 1'b0;
        repeat (4) @(posedge clk);
        mon_en = 1;

        pl[0] = 8'h11; pl[1] = 8'h22;
        do_frame(HDR, 8'h03, 8'd2, 8'h00, -1);
        drain(50);
        chk("tx_after_first_good", int'(bus.tx_data), 8'h10);
        do_frame(HDR, 8'h03, 8'd2, 8'h01, -1);
        drain(50);

        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        do_frame(HDR, 8'h0E, 8'd3, 8'h00, -1);
        drain(50);

        do_frame(HDR, 8'h07, 8'd0, 8'h00, -1);
        drain(50);
        do_frame(HDR, 8'h07, 8'd9, 8'h00, -1);
        drain(50);
        do_frame(HDR, 8'h07, 8'd8, 8'h00, -1);
        drain(50);

        foreach (pl[i]) pl[i] = 8'($urandom);
        send_byte(HDR, 0, r);
        send_byte(8'h02, 0, r);
        send_byte(8'd4, 0, r);
        send_byte(pl[0], 0, r);
        send_byte(pl[1], 0, r);
        push_err(ERR_CS_ABORT, -1);
        cs_n = 1'b1;
        drain(20);
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        do_frame(HDR, 8'h09, 8'd3, 8'h00, -1);
        drain(50);

        do_frame(HDR, 8'h01, 8'd4, 8'h00, 0);
        drain(50);
        do_frame(HDR, 8'h0C, 8'd5, 8'h00, 3);
        drain(50);

        for (int n = 0; n < 40; n++) begin
            int kind;
            foreach (pl[i]) pl[i] = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                do_frame(b, 8'h00, 8'd1, 8'h00, -1);
            end else if (kind == 1) begin
                b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                do_frame(HDR, 8'($urandom), b, 8'h00, -1);
            end else if (kind == 2) begin
                do_frame(HDR, 8'($urandom), 8'($urandom_range(1, MAX_LEN)),
                         8'd1 << $urandom_range(0, 7), -1);
            end else begin
                do_frame(HDR, 8'($urandom), 8'($urandom_range(1, MAX_LEN)), 8'h00, -1);
            end
            drain(80);
        end

        send_byte(HDR, 0, r);
        send_byte(8'h01, 0, r);
        send_byte(8'd3, 0, r);
        send_byte(pl[0], 0, r);
        send_byte(pl[1], 0, r);
        push_err(ERR_TIMEOUT, r + TIMEOUT);
        drain(TIMEOUT + 20);

        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        send_byte(HDR, 0, r);
        send_byte(8'h00, 0, r);
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'h3C, 0, r);
        push_err(ERR_BAD_HDR, r + 1);
        drain(20);

        foreach (pl[i]) pl[i] = 8'($urandom);
        do_frame(HDR, 8'h05, 8'd8, 8'h00, -1);
        @(posedge clk); #1;
        chk("wr_en_before_reset", int'(bus.wr_en), 1);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_zero("midcommit_reset");
        wq.delete(); eq.delete(); okq.delete();
        exp_cnt = '0;
        exp_err = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        mon_en = 1;
        do_frame(HDR, 8'h0A, 8'd2, 8'h00, -1);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
